// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin arbiter in front of a single APB master.
// Each requester holds req[i] until it gets a one-cycle ack[i]. The winner's direction,
// address and write data are latched at grant. The transfer then runs SETUP and ACCESS.
// A read adds an RDCAP cycle, because the slave registers prdata one cycle after ACCESS.
//
// Ports:
//   pclk, presetn       clock; asynchronous active-low reset
//   req, we             per-requester request and direction (1 = write)
//   addr0/1, wdata0/1   per-requester address and write data
//   ack                 one-cycle completion pulse per requester
//   rdata               data of the most recent completed read
//   busy                high whenever the FSM is not idle
//   psel, penable, pwrite, paddr, pwdata, prdata   APB master side (no pready)
module apb_master_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRdcap} state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;     // requester granted most recently
    logic              owner_q, owner_d;   // requester owning the current transfer
    logic              we_q, we_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        ack_q, ack_d;

    logic [1:0] eligible;
    logic       winner;

    // A requester in its own ack cycle is masked, so the other side can be granted
    // in that cycle without an idle gap.
    assign eligible = req & ~ack_q;

    always_comb begin
        unique case (eligible)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last_q;  // tie: the side not granted last
        endcase
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        ack_d    = 2'b00;
        case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d  = StSetup;
                    owner_d  = winner;
                    last_d   = winner;
                    we_d     = we[winner];
                    paddr_d  = winner ? addr1 : addr0;
                    pwdata_d = winner ? wdata1 : wdata0;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (we_q) begin
                    state_d        = StIdle;
                    ack_d[owner_q] = 1'b1;
                end else begin
                    state_d = StRdcap;
                end
            end
            StRdcap: begin
                rdata_d        = prdata;
                ack_d[owner_q] = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
        end
    end

    // Controls decode straight from the state so an asynchronous reset drops them at once.
    assign psel    = (state_q == StSetup) || (state_q == StAccess);
    assign penable = (state_q == StAccess);
    assign pwrite  = psel & we_q;
    assign busy    = (state_q != StIdle);
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign rdata   = rdata_q;
    assign ack     = ack_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed bench for apb_master_arbiter with a small APB slave model.
// Slave map: five word registers at 0x0..0x10; any other address reads as zero.
module tb_apb_master_arbiter;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic        sl_rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [1:0]  ack;
    logic [31:0] rdata, paddr, pwdata, prdata;
    logic        busy, psel, penable, pwrite;

    int n_vec = 0;
    int n_miss = 0;

    always #5 pclk = ~pclk;

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .pclk(pclk), .presetn(presetn), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .busy(busy), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
    );

    // Slave model: registered read data, writes on the ACCESS edge; not reset by presetn.
    logic [31:0] sregs [8];
    logic        mapped;
    assign mapped = (paddr < 32'h14) && (paddr[1:0] == 2'b00);

    always @(posedge pclk or negedge sl_rst_n) begin
        if (!sl_rst_n) begin
            sregs[0] <= 32'h0000_0000;
            sregs[1] <= 32'h5A5A_5555;
            sregs[2] <= 32'h0000_0000;
            sregs[3] <= 32'hA5A5_0000;
            sregs[4] <= 32'h0000_FFFF;
            sregs[5] <= '0;
            sregs[6] <= '0;
            sregs[7] <= '0;
            prdata   <= '0;
        end else if (psel && penable) begin
            if (pwrite) begin
                if (mapped) sregs[paddr[4:2]] <= pwdata;
            end else begin
                prdata <= mapped ? sregs[paddr[4:2]] : 32'h0;
            end
        end
    end

    typedef struct {
        logic        id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;  // rdata required in the ack cycle
        string       name;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Request seen at the end of the current cycle (c0); checks every phase through ack.
    task automatic do_xfer(input vec_t v);
        logic [1:0] oh;
        oh = v.id ? 2'b10 : 2'b01;
        req[v.id] = 1'b1;
        we[v.id]  = v.wr;
        if (v.id) begin addr1 = v.addr; wdata1 = v.wdata; end
        else      begin addr0 = v.addr; wdata0 = v.wdata; end
        tick();  // c1: SETUP
        chk({v.name, ".setup"}, {58'd0, psel, penable, pwrite, busy, ack},
            {58'd0, 1'b1, 1'b0, v.wr, 1'b1, 2'b00});
        chk({v.name, ".paddr"}, {32'd0, paddr}, {32'd0, v.addr});
        if (v.wr) chk({v.name, ".pwdata"}, {32'd0, pwdata}, {32'd0, v.wdata});
        // Inputs change after grant; the latched transfer must not follow them.
        we[v.id] = ~v.wr;
        if (v.id) begin addr1 = ~v.addr; wdata1 = ~v.wdata; end
        else      begin addr0 = ~v.addr; wdata0 = ~v.wdata; end
        tick();  // c2: ACCESS
        chk({v.name, ".access"}, {58'd0, psel, penable, pwrite, busy, ack},
            {58'd0, 1'b1, 1'b1, v.wr, 1'b1, 2'b00});
        chk({v.name, ".paddr2"}, {32'd0, paddr}, {32'd0, v.addr});
        if (!v.wr) begin
            tick();  // c3: RDCAP
            chk({v.name, ".rdcap"}, {58'd0, psel, penable, pwrite, busy, ack},
                {58'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00});
        end
        tick();  // ack cycle
        req[v.id] = 1'b0;
        chk({v.name, ".ack"}, {58'd0, psel, penable, pwrite, busy, ack},
            {58'd0, 1'b0, 1'b0, 1'b0, 1'b0, oh});
        chk({v.name, ".rdata"}, {32'd0, rdata}, {32'd0, v.exp_rdata});
        chk({v.name, ".hold"}, {32'd0, paddr}, {32'd0, v.addr});
        tick();
        chk({v.name, ".pulse"}, {62'd0, ack}, {62'd0, 2'b00});
    endtask

    // Waits for the next ack and checks which bit and after how many edges.
    task automatic wait_ack(input logic [1:0] exp, input int exp_cyc, input string name);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ack != 2'b00) begin
                chk({name, ".ack"}, {62'd0, ack}, {62'd0, exp});
                chk({name, ".lat"}, 64'(c), 64'(exp_cyc));
                return;
            end
        end
        chk({name, ".timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int k0, k1, n_ack, gap, exp_id;
        vecs[0] = '{1'b1, 1'b0, 32'h4,  32'h0,         32'h5A5A_5555, "rd_reg1"};
        vecs[1] = '{1'b0, 1'b1, 32'h8,  32'hDEAD_BEEF, 32'h5A5A_5555, "wr_reg2"};
        vecs[2] = '{1'b0, 1'b0, 32'h8,  32'h0,         32'hDEAD_BEEF, "rd_reg2"};
        vecs[3] = '{1'b1, 1'b1, 32'h0,  32'h1234_5678, 32'hDEAD_BEEF, "wr_reg0"};
        vecs[4] = '{1'b1, 1'b0, 32'h0,  32'h0,         32'h1234_5678, "rd_reg0"};
        vecs[5] = '{1'b0, 1'b0, 32'h14, 32'h0,         32'h0000_0000, "rd_unmap"};

        #1 presetn = 1'b0;
        repeat (2) tick();
        chk("reset.ctl", {58'd0, psel, penable, pwrite, busy, ack}, 64'd0);
        chk("reset.data", {paddr, pwdata}, 64'd0);
        chk("reset.rdata", {32'd0, rdata}, 64'd0);
        presetn  = 1'b1;
        sl_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

        // Tie after reset: requester 0 first, then 1 granted straight out of the ack cycle.
        presetn = 1'b0;
        tick();
        chk("rst2.rdata", {32'd0, rdata}, 64'd0);
        chk("rst2.paddr", {32'd0, paddr}, 64'd0);
        presetn = 1'b1;
        tick();
        we = 2'b00; addr0 = 32'h10; addr1 = 32'hC;
        req = 2'b11;
        wait_ack(2'b01, 4, "tie.first");
        req[0] = 1'b0;
        chk("tie.rdata0", {32'd0, rdata}, {32'd0, 32'h0000_FFFF});
        wait_ack(2'b10, 4, "tie.second");
        req[1] = 1'b0;
        chk("tie.rdata1", {32'd0, rdata}, {32'd0, 32'hA5A5_0000});
        tick();

        // Fairness: four back-to-back writes from each side must alternate 0,1,0,1...
        k0 = 0; k1 = 0; n_ack = 0; gap = 0; exp_id = 0;
        we = 2'b11;
        addr0 = 32'h0; wdata0 = 32'hA000_0000;
        addr1 = 32'h8; wdata1 = 32'hB000_0000;
        req = 2'b11;
        for (int c = 0; c < 60 && n_ack < 8; c++) begin
            tick();
            gap++;
            if (ack != 2'b00) begin
                chk("fair.order", {62'd0, ack}, {62'd0, (exp_id == 0) ? 2'b01 : 2'b10});
                if (gap > 4) chk("fair.gap", 64'(gap), 64'd4);
                gap = 0;
                n_ack++;
                exp_id = 1 - exp_id;
                if (ack[0]) begin
                    k0++;
                    if (k0 == 4) req[0] = 1'b0;
                    else wdata0 = 32'hA000_0000 + 32'(k0);
                end
                if (ack[1]) begin
                    k1++;
                    if (k1 == 4) req[1] = 1'b0;
                    else wdata1 = 32'hB000_0000 + 32'(k1);
                end
            end
        end
        chk("fair.count", 64'(n_ack), 64'd8);
        chk("fair.reg0", {32'd0, sregs[0]}, {32'd0, 32'hA000_0003});
        chk("fair.reg2", {32'd0, sregs[2]}, {32'd0, 32'hB000_0003});
        tick();

        // Reset during ACCESS of a write to 0xC: controls drop without a clock edge.
        we[0] = 1'b1; addr0 = 32'hC; wdata0 = 32'hBAD0_BAD0;
        req[0] = 1'b1;
        tick();
        tick();
        chk("mid.access", {62'd0, psel, penable}, {62'd0, 2'b11});
        #2 presetn = 1'b0;
        #1;
        chk("mid.async", {58'd0, psel, penable, pwrite, busy, ack}, 64'd0);
        req = 2'b00;
        tick();
        #3 presetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid.noack", {61'd0, ack, busy}, 64'd0);
        end
        chk("mid.reg3", {32'd0, sregs[3]}, {32'd0, 32'hA5A5_0000});

        do_xfer('{1'b1, 1'b0, 32'hC, 32'h0, 32'hA5A5_0000, "resume"});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width of the requester and APB address buses.
REQ-002 SHALL have parameter DATA_W, default 32, the data width of the requester and APB data buses.
REQ-003 SHALL have port pclk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port presetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  transfer request, bit i from requester i, held high until ack[i].
REQ-006 SHALL have port we  input  2  per-requester direction: 1 = write, 0 = read.
REQ-007 SHALL have ports addr0, addr1  input  ADDR_W  per-requester byte address.
REQ-008 SHALL have ports wdata0, wdata1  input  DATA_W  per-requester write data.
REQ-009 SHALL have port ack  output  2  one-cycle completion pulse, bit i for requester i.
REQ-010 SHALL have port rdata  output  DATA_W  read data of the most recent completed read.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have ports psel, penable, pwrite  output  1 each  APB master control.
REQ-013 SHALL have ports paddr  output  ADDR_W and pwdata  output  DATA_W  APB address and write data.
REQ-014 SHALL have port prdata  input  DATA_W  APB read data; the slave registers it, so it is valid one cycle after the ACCESS phase; the slave has no pready.

Function
REQ-015 SHALL implement the FSM states IDLE, SETUP, ACCESS and RDCAP.
REQ-016 SHALL arbitrate in IDLE on eligible = req & ~ack: if no bit is set, stay in IDLE; otherwise go to SETUP.
REQ-017 SHALL arbitrate round-robin: a single eligible requester wins, and on a tie the requester not granted last wins.
REQ-018 SHALL reset the last-granted pointer to 1, so requester 0 wins the first tie.
REQ-019 SHALL latch the winner's we, addr and wdata on the IDLE->SETUP edge, and SHALL ignore later changes to those inputs until ack.
REQ-020 SHALL drive SETUP as psel=1, penable=0 and ACCESS as psel=1, penable=1; pwrite, paddr and pwdata are the latched values, stable across both phases.
REQ-021 SHALL make SETUP->ACCESS unconditional; from ACCESS, a write goes to IDLE and a read goes to RDCAP.
REQ-022 SHALL drive RDCAP as psel=0, penable=0 and pwrite=0, capture prdata into rdata, then go to IDLE.
REQ-023 SHALL assert ack[winner], registered, for exactly one cycle on the first IDLE cycle after the transfer.
  - Write: request seen at cycle 0 gives SETUP c1, ACCESS c2, ack c3.
  - Read: request seen at cycle 0 gives SETUP c1, ACCESS c2, RDCAP c3, ack c4.
REQ-024 SHALL make rdata valid in the read's ack cycle and hold it until the next read's capture; writes do not alter rdata.
REQ-025 SHALL drive psel=0, penable=0 and pwrite=0 in IDLE, with paddr and pwdata holding their last values.
REQ-026 SHALL let a requester still high during its own ack cycle compete only from the following cycle.
REQ-027 SHALL let the other requester's pending req be granted in that ack cycle, giving back-to-back SETUP with no idle gap.
REQ-028 SHALL never serve a req dropped before grant, and SHALL never assert both ack bits in the same cycle.
REQ-029 SHALL pass addresses through unmodified; decode and alignment are the slave's concern.

Reset
REQ-030 SHALL, while presetn=0, force IDLE immediately (asynchronously), abandon any in-flight transfer without ack, and set:
  - psel, penable, pwrite = 0; ack = 0; busy = 0;
  - paddr, pwdata, rdata = 0; last-granted pointer = 1.
REQ-031 SHALL resume arbitration on the first rising pclk edge after presetn deasserts.

Verification
REQ-032 SHALL cover a write: after reset, req0 write addr 0x8 data 0xDEADBEEF -> psel c1-c2, penable c2, ack[0] c3; a subsequent read of 0x8 returns 0xDEADBEEF.
REQ-033 SHALL cover a read of reset state: after reset, req1 read addr 0x4 -> RDCAP c3, ack[1] c4, rdata = 0x5A5A5555; the ack[0] bit stays 0 throughout.
REQ-034 SHALL cover a tie: after reset, req=2'b11 same cycle, both reads, addr0=0x10, addr1=0xC -> requester 0 first (rdata 0x0000FFFF), then requester 1 (rdata 0xA5A50000).
REQ-035 SHALL cover fairness: both requesters issuing four writes each continuously -> grants alternate 0,1,0,1,... and no ack gap exceeds 4 cycles for writes.
REQ-036 SHALL cover reset mid-transfer: presetn low during ACCESS of a write to 0xC -> psel and penable fall without waiting for a pclk edge, no ack, busy=0, and slave reg3 is unchanged.
REQ-037 SHALL cover an unmapped read: read addr 0x14 -> ack after 4 cycles, rdata = 0x00000000.
